// File: rtl/apb_spi_master_fifo.sv
// APB-slave SPI master with TX/RX FIFOs, configurable frame width and multiple slave selects.
// Optional interrupt register at 0x14 is built when APB_SPI_IRQ_EN is defined.
module apb_spi_master_fifo #(
  parameter int DATA_W = 8,
  parameter int FIFO_D = 4,
  parameter int NUM_SS = 2,
  parameter int DIV_W  = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  input  logic              MSI,
  output logic              MSO,
  output logic              SCLK,
  output logic [NUM_SS-1:0] SSn,
  output logic              IRQ
);

  localparam int AW = $clog2(FIFO_D);
  localparam int LW = AW + 1;
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  logic wr_en, rd_en;
  logic [2:0] reg_sel;

  logic [3:0]        ctrl_q, ctrl_d;
  logic [NUM_SS-1:0] ss_q, ss_d;
  logic [DIV_W-1:0]  clkdiv_q, clkdiv_d;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;

  logic [DATA_W-1:0] tx_mem_q [FIFO_D];
  logic [DATA_W-1:0] rx_mem_q [FIFO_D];
  logic [AW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [LW-1:0]     tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_push_req, frame_done;

  state_t            state_q, state_d;
  logic              cpol_f_q, cpol_f_d, cpha_f_q, cpha_f_d, lsb_f_q, lsb_f_d;
  logic [DIV_W-1:0]  div_f_q, div_f_d, div_cnt_q, div_cnt_d;
  logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, tx_head, tx_shifted;
  logic              sclk_q, sclk_d, mso_q, mso_d;
  logic              half_done, odd_edge, do_sample, do_shift;

  assign wr_en   = PSEL & PENABLE & PWRITE;
  assign rd_en   = PSEL & PENABLE & ~PWRITE;
  assign reg_sel = PADDR[4:2];
  assign PREADY  = 1'b1;

  assign tx_empty = (tx_lvl_q == '0);
  assign tx_full  = (tx_lvl_q == LW'(FIFO_D));
  assign rx_empty = (rx_lvl_q == '0);
  assign rx_full  = (rx_lvl_q == LW'(FIFO_D));

  assign tx_push = wr_en && (reg_sel == 3'd0) && !tx_full;
  assign rx_pop  = rd_en && (reg_sel == 3'd1) && !rx_empty;
  // A same-cycle pop frees the slot the engine is about to fill.
  assign rx_push = rx_push_req && (!rx_full || rx_pop);
  assign tx_head = tx_mem_q[tx_rp_q];

  assign MSO  = mso_q;
  assign SCLK = sclk_q;
  assign SSn  = ~ss_q;

  // Registers and FIFO pointers.
  always_comb begin
    ctrl_d   = ctrl_q;
    ss_d     = ss_q;
    clkdiv_d = clkdiv_q;
    if (wr_en && reg_sel == 3'd2) begin
      ctrl_d = PWDATA[3:0];
      ss_d   = PWDATA[8 +: NUM_SS];
    end
    if (wr_en && reg_sel == 3'd3) clkdiv_d = PWDATA[DIV_W-1:0];
    tx_ovf_d = (wr_en && reg_sel == 3'd0 && tx_full) |
               (tx_ovf_q & ~(wr_en && reg_sel == 3'd4 && PWDATA[5]));
    rx_ovf_d = (rx_push_req && rx_full && !rx_pop) |
               (rx_ovf_q & ~(wr_en && reg_sel == 3'd4 && PWDATA[6]));
    tx_wp_d  = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + 1'b1 : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
    tx_lvl_d = tx_lvl_q + LW'(tx_push) - LW'(tx_pop);
    rx_lvl_d = rx_lvl_q + LW'(rx_push) - LW'(rx_pop);
  end

  // Shift engine.
  always_comb begin
    state_d    = state_q;
    cpol_f_d   = cpol_f_q;
    cpha_f_d   = cpha_f_q;
    lsb_f_d    = lsb_f_q;
    div_f_d    = div_f_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    sclk_d     = sclk_q;
    mso_d      = mso_q;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    frame_done  = 1'b0;
    half_done  = (div_cnt_q == div_f_q);
    odd_edge   = ~edge_cnt_q[0];
    do_sample  = cpha_f_q ? ~odd_edge : odd_edge;
    do_shift   = ~do_sample;
    tx_shifted = lsb_f_q ? {1'b0, tx_sh_q[DATA_W-1:1]} : {tx_sh_q[DATA_W-2:0], 1'b0};
    unique case (state_q)
      ST_IDLE: begin
        sclk_d = ctrl_q[1];
        if (ctrl_q[0] && !tx_empty) begin
          tx_pop     = 1'b1;
          state_d    = ST_SHIFT;
          cpol_f_d   = ctrl_q[1];
          cpha_f_d   = ctrl_q[2];
          lsb_f_d    = ctrl_q[3];
          div_f_d    = clkdiv_q;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          tx_sh_d    = tx_head;
          rx_sh_d    = '0;
          if (!ctrl_q[2]) mso_d = ctrl_q[3] ? tx_head[0] : tx_head[DATA_W-1];
        end
      end
      ST_SHIFT: begin
        if (half_done) begin
          div_cnt_d  = '0;
          edge_cnt_d = edge_cnt_q + 1'b1;
          sclk_d     = ~sclk_q;
          if (do_sample)
            rx_sh_d = lsb_f_q ? {MSI, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], MSI};
          if (do_shift) begin
            tx_sh_d = tx_shifted;
            // CPHA=1 drives the current bit; CPHA=0 already drove it and moves to the next.
            if (cpha_f_q) mso_d = lsb_f_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
            else          mso_d = lsb_f_q ? tx_shifted[0] : tx_shifted[DATA_W-1];
          end
          if (edge_cnt_q == LAST_EDGE) begin
            rx_push_req = 1'b1;
            frame_done  = 1'b1;
            state_d     = ST_GAP;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (half_done) begin
          div_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl_q     <= '0;
      ss_q       <= '0;
      clkdiv_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_lvl_q   <= '0;
      rx_lvl_q   <= '0;
      state_q    <= ST_IDLE;
      cpol_f_q   <= 1'b0;
      cpha_f_q   <= 1'b0;
      lsb_f_q    <= 1'b0;
      div_f_q    <= '0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      sclk_q     <= 1'b0;
      mso_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      ss_q       <= ss_d;
      clkdiv_q   <= clkdiv_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_lvl_q   <= tx_lvl_d;
      rx_lvl_q   <= rx_lvl_d;
      state_q    <= state_d;
      cpol_f_q   <= cpol_f_d;
      cpha_f_q   <= cpha_f_d;
      lsb_f_q    <= lsb_f_d;
      div_f_q    <= div_f_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      sclk_q     <= sclk_d;
      mso_q      <= mso_d;
    end
  end

  // FIFO storage needs no reset: the pointers define what is valid.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= PWDATA[DATA_W-1:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_sh_d;
  end

`ifdef APB_SPI_IRQ_EN
  logic [3:0] ie_q, ie_d, is_vec;
  logic       fd_q, fd_d, irq_q, irq_d;

  assign is_vec = {tx_ovf_q | rx_ovf_q, fd_q, ~rx_empty, tx_empty};
  assign IRQ    = irq_q;

  always_comb begin
    ie_d  = ie_q;
    if (wr_en && reg_sel == 3'd5) ie_d = PWDATA[3:0];
    fd_d  = frame_done | (fd_q & ~(wr_en && reg_sel == 3'd5 && PWDATA[10]));
    irq_d = |(ie_q & is_vec);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ie_q  <= '0;
      fd_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      fd_q  <= fd_d;
      irq_q <= irq_d;
    end
  end
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    PRDATA = '0;
    unique case (reg_sel)
      3'd1: if (!rx_empty) PRDATA[DATA_W-1:0] = rx_mem_q[rx_rp_q];
      3'd2: begin
        PRDATA[3:0]          = ctrl_q;
        PRDATA[8 +: NUM_SS]  = ss_q;
      end
      3'd3: PRDATA[DIV_W-1:0] = clkdiv_q;
      3'd4: begin
        PRDATA[6:0]   = {rx_ovf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty,
                         state_q != ST_IDLE};
        PRDATA[15:8]  = 8'(tx_lvl_q);
        PRDATA[23:16] = 8'(rx_lvl_q);
      end
`ifdef APB_SPI_IRQ_EN
      3'd5: begin
        PRDATA[3:0]  = ie_q;
        PRDATA[11:8] = is_vec;
      end
`endif
      default: PRDATA = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{PADDR[31:5], PADDR[1:0], PWDATA, cpol_f_q};

endmodule
